// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-channel round-robin arbiter.
package arb_pkg;
  localparam int N_CH = 4;

  typedef logic [1:0] sel_t;
endpackage

// File: rtl/rr_grant_4.sv
// Round-robin grant search starting at ptr: combinational (0 cycles).
// Has no state and no backpressure: grant follows req/ptr directly.
module rr_grant_4
  import arb_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  sel_t            ptr,
  output logic [N_CH-1:0] grant,
  output sel_t            gnt_idx,
  output logic            any
);

  logic w_found;
  sel_t w_idx;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = '0;
    // Walk ptr, ptr+1, ... with natural 2-bit wrap; the first request seen wins.
    for (int k = 0; k < N_CH; k++) begin
      w_idx = ptr + sel_t'(k);
      if (!w_found && req[w_idx]) begin
        w_found        = 1'b1;
        grant[w_idx]   = 1'b1;
        gnt_idx        = w_idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/arb_4_1_rr.sv
// 4:1 round-robin arbiter with registered output; beat appears 1 cycle after accept.
// Backpressure: out_valid & ~out_ready stalls all channels; drain and refill overlap.
module arb_4_1_rr
  import arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in_valid,
  output logic [N_CH-1:0] in_ready,
  input  logic [W-1:0]    in_data0,
  input  logic [W-1:0]    in_data1,
  input  logic [W-1:0]    in_data2,
  input  logic [W-1:0]    in_data3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output sel_t            out_sel
);

  sel_t            r_ptr;
  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  sel_t            r_out_sel;

  logic [N_CH-1:0] w_grant;
  sel_t            w_gnt_idx;
  logic            w_any;
  logic            w_load_en;
  logic [W-1:0]    w_data;

  rr_grant_4 u_grant (
    .req     (in_valid),
    .ptr     (r_ptr),
    .grant   (w_grant),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_load_en = ~r_out_valid | out_ready;
  // Reset also masks accepts, so no channel sees a handshake while held in reset.
  assign in_ready  = (rst_n && w_load_en) ? w_grant : '0;

  // Index encoding matches the downstream 4:1 mux (0 -> d0 ... 3 -> d3).
  always_comb begin
    w_data = in_data0;
    case (w_gnt_idx)
      2'd0: w_data = in_data0;
      2'd1: w_data = in_data1;
      2'd2: w_data = in_data2;
      2'd3: w_data = in_data3;
      default: w_data = in_data0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_sel   <= w_gnt_idx;
        r_ptr       <= w_gnt_idx + sel_t'(1);
      end else begin
        // Drain without refill: payload and sel keep their last values.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
